// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: register map,
// control word layout, FSM states and the codec bring-up table.
package wm8731_pkg;

  localparam int         NREGS    = 10;
  localparam logic [6:0] DEV_ADDR = 7'h1A;
  localparam int         RST_DLY  = 1024;
  localparam int         IDX_W    = $clog2(NREGS);
  localparam int         DLY_W    = $clog2(RST_DLY + 1);

  localparam logic [6:0] R0  = 7'h00;
  localparam logic [6:0] R1  = 7'h01;
  localparam logic [6:0] R2  = 7'h02;
  localparam logic [6:0] R3  = 7'h03;
  localparam logic [6:0] R4  = 7'h04;
  localparam logic [6:0] R5  = 7'h05;
  localparam logic [6:0] R6  = 7'h06;
  localparam logic [6:0] R7  = 7'h07;
  localparam logic [6:0] R8  = 7'h08;
  localparam logic [6:0] R9  = 7'h09;
  localparam logic [6:0] R15 = 7'h0F;

  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } wm8731_word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    RELEASE,
    DELAY,
    DONE
  } state_e;

  // Soft reset must come first and the active bit (R9) last, after R7/R8.
  localparam wm8731_word_t INIT_TABLE [NREGS] = '{
    '{addr: R15, data: 9'h000},
    '{addr: R6,  data: 9'h062},
    '{addr: R0,  data: 9'h117},
    '{addr: R2,  data: 9'h179},
    '{addr: R3,  data: 9'h079},
    '{addr: R4,  data: 9'h012},
    '{addr: R5,  data: 9'h000},
    '{addr: R7,  data: 9'h002},
    '{addr: R8,  data: 9'h000},
    '{addr: R9,  data: 9'h001}
  };

  function automatic logic [1:0][7:0] packWord(input wm8731_word_t w);
    return {w.addr, w.data};
  endfunction

endpackage

// File: rtl/wm8731_init_rom.sv
// Combinational lookup of the codec bring-up table by entry index.
module wm8731_init_rom
  import wm8731_pkg::*;
(
  input  logic [IDX_W-1:0] index_i,
  output wm8731_word_t     word_o
);

  always_comb begin
    word_o = '0;
    if (int'(index_i) < NREGS) word_o = INIT_TABLE[index_i];
  end

endmodule

// File: rtl/wm8731_config_sequencer.sv
// Walks the WM8731 init table, issuing one 2-byte I2C write per entry.
// Define WM8731_VOLUME_EN to add runtime headphone volume writes once configured.
module wm8731_config_sequencer
  import wm8731_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            i2c_req,
  input  logic            i2c_ack,
`ifdef WM8731_VOLUME_EN
  input  logic            vol_valid,
  input  logic [6:0]      vol_data,
  output logic            vol_ready,
`endif
  output logic [6:0]      i2c_addr,
  output logic [1:0][7:0] i2c_wdata
);

  state_e           state_q;
  logic [IDX_W-1:0] index_q;
  logic [DLY_W-1:0] dlyCnt_q;
  logic [1:0][7:0]  wdata_q;
  logic             req_q;
  logic             busy_q;
  logic             done_q;
  wm8731_word_t     romWord;
  wm8731_word_t     loadWord_d;

  wm8731_init_rom uRom (
    .index_i (index_q),
    .word_o  (romWord)
  );

`ifdef WM8731_VOLUME_EN
  logic       volWrite_q;
  logic [6:0] volData_q;

  assign vol_ready = (state_q == DONE);

  // Both headphone channels follow the left setting, with zero-cross enabled.
  always_comb begin
    loadWord_d = romWord;
    if (volWrite_q) loadWord_d = '{addr: R2, data: {2'b11, volData_q}};
  end
`else
  always_comb loadWord_d = romWord;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      index_q  <= '0;
      dlyCnt_q <= '0;
      wdata_q  <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef WM8731_VOLUME_EN
      volWrite_q <= 1'b0;
      volData_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            index_q <= '0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          wdata_q <= packWord(loadWord_d);
          req_q   <= 1'b1;
          state_q <= WRITE;
        end
        WRITE: begin
          if (i2c_ack) begin
            req_q   <= 1'b0;
            state_q <= RELEASE;
          end
        end
        // Waiting for ack to drop keeps a held ack from launching a second frame.
        RELEASE: begin
          if (!i2c_ack) begin
`ifdef WM8731_VOLUME_EN
            if (volWrite_q) begin
              volWrite_q <= 1'b0;
              busy_q     <= 1'b0;
              state_q    <= DONE;
            end else
`endif
            if (index_q == IDX_W'(NREGS - 1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else if (index_q == '0) begin
              dlyCnt_q <= DLY_W'(RST_DLY);
              state_q  <= DELAY;
            end else begin
              index_q <= index_q + 1'b1;
              state_q <= LOAD;
            end
          end
        end
        DELAY: begin
          if (dlyCnt_q == DLY_W'(1)) begin
            index_q <= IDX_W'(1);
            state_q <= LOAD;
          end else begin
            dlyCnt_q <= dlyCnt_q - 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            index_q <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end
`ifdef WM8731_VOLUME_EN
          else if (vol_valid) begin
            volWrite_q <= 1'b1;
            volData_q  <= vol_data;
            busy_q     <= 1'b1;
            state_q    <= LOAD;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign i2c_req   = req_q;
  assign i2c_addr  = DEV_ADDR;
  assign i2c_wdata = wdata_q;

endmodule

// File: tb/tb_wm8731_config_sequencer.sv
// Self-checking bench for wm8731_config_sequencer with a behavioural I2C controller
// (ack high 4 clk, a random or fixed number of clk after req).
module tb_wm8731_config_sequencer;

  localparam int NENT   = 10;
  localparam int DLY    = 1024;
  localparam int BUDGET = 5000;

  typedef struct {
    int ackDly;
    int spurAt;
    int expWrites;
    int expDoneRises;
  } vec_t;

  logic            clk;
  logic            reset;
  logic            start;
  logic            busy;
  logic            done;
  logic            i2c_req;
  logic            i2c_ack;
  logic [6:0]      i2c_addr;
  logic [1:0][7:0] i2c_wdata;
`ifdef WM8731_VOLUME_EN
  logic            vol_valid;
  logic [6:0]      vol_data;
  logic            vol_ready;
`endif

  int compared;
  int mismatched;

  // Reference: register address and 9-bit data of each bring-up entry, in order.
  int refAddr [NENT];
  int refData [NENT];

  logic [15:0] writes[$];
  int          riseCyc[$];
  int          ackFallCyc[$];
  int          reqRises;
  int          doneRises;
  int          stableErrs;
  int          reqDuringAckErrs;
  int          ackDlyMode;
  int          ctlCyc;

  wm8731_config_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .i2c_req   (i2c_req),
    .i2c_ack   (i2c_ack),
`ifdef WM8731_VOLUME_EN
    .vol_valid (vol_valid),
    .vol_data  (vol_data),
    .vol_ready (vol_ready),
`endif
    .i2c_addr  (i2c_addr),
    .i2c_wdata (i2c_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural write-only I2C controller: logs every frame and checks the handshake.
  initial begin
    int phase;
    int dly;
    int hold;
    logic prevReq;
    logic [15:0] curWord;
    i2c_ack = 1'b0;
    phase   = 0;
    dly     = 0;
    hold    = 0;
    prevReq = 1'b0;
    curWord = '0;
    forever begin
      @(negedge clk);
      ctlCyc++;
      if (reset) begin
        i2c_ack = 1'b0;
        phase   = 0;
        prevReq = 1'b0;
      end else begin
        if (i2c_req && !prevReq) begin
          reqRises++;
          riseCyc.push_back(ctlCyc);
          if (i2c_ack) reqDuringAckErrs++;
        end
        prevReq = i2c_req;
        case (phase)
          0: if (i2c_req) begin
            curWord = i2c_wdata;
            writes.push_back(curWord);
            dly   = (ackDlyMode < 0) ? int'($urandom_range(0, 5)) : ackDlyMode;
            phase = 1;
          end
          1: begin
            if (i2c_wdata != curWord) stableErrs++;
            if (dly == 0) begin
              i2c_ack = 1'b1;
              hold    = 3;
              phase   = 2;
            end else dly--;
          end
          default: begin
            if (i2c_req) reqDuringAckErrs++;
            if (i2c_wdata != curWord) stableErrs++;
            if (hold == 0) begin
              i2c_ack = 1'b0;
              ackFallCyc.push_back(ctlCyc);
              phase = 0;
            end else hold--;
          end
        endcase
      end
    end
  end

  initial begin
    logic prevDone;
    prevDone = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) prevDone = 1'b0;
      else begin
        if (done && !prevDone) doneRises++;
        prevDone = done;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    writes.delete();
    riseCyc.delete();
    ackFallCyc.delete();
    reqRises         = 0;
    doneRises        = 0;
    stableErrs       = 0;
    reqDuringAckErrs = 0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(output bit timedOut);
    timedOut = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic checkTable(input string tag);
    int n;
    n = (writes.size() < NENT) ? writes.size() : NENT;
    for (int k = 0; k < n; k++)
      checkOutput($sformatf("%s.wdata[%0d]", tag, k), int'(writes[k]), refAddr[k] * 512 + refData[k]);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    bit timedOut;
    bit spurSent;
    int gapErrs;
    string tag;
    tag        = $sformatf("vec%0d", idx);
    ackDlyMode = v.ackDly;
    doReset();
    pulseStart();
    spurSent = 1'b0;
    timedOut = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (v.spurAt >= 0 && !spurSent && reqRises == v.spurAt + 1) begin
        checkOutput({tag, ".busyAtSpurStart"}, int'(busy), 1);
        start    = 1'b1;
        spurSent = 1'b1;
      end
      if (done) begin
        timedOut = 1'b0;
        break;
      end
    end
    start = 1'b0;
    checkOutput({tag, ".timeout"}, int'(timedOut), 0);
    repeat (40) @(negedge clk);
    checkOutput({tag, ".writes"}, writes.size(), v.expWrites);
    checkOutput({tag, ".reqRises"}, reqRises, v.expWrites);
    checkOutput({tag, ".doneRises"}, doneRises, v.expDoneRises);
    checkOutput({tag, ".doneAfter"}, int'(done), 1);
    checkOutput({tag, ".busyAfter"}, int'(busy), 0);
    checkOutput({tag, ".addr"}, int'(i2c_addr), 'h1A);
    checkOutput({tag, ".wdataStable"}, stableErrs, 0);
    checkOutput({tag, ".reqDuringAck"}, reqDuringAckErrs, 0);
    checkTable(tag);
    // The soft-reset gap exceeds an ordinary inter-frame gap by exactly the delay.
    if (riseCyc.size() >= NENT && ackFallCyc.size() >= NENT) begin
      checkOutput({tag, ".resetGap"}, (riseCyc[1] - ackFallCyc[0]) - (riseCyc[2] - ackFallCyc[1]), DLY);
      gapErrs = 0;
      for (int k = 2; k < NENT - 1; k++)
        if ((riseCyc[k + 1] - ackFallCyc[k]) != (riseCyc[2] - ackFallCyc[1])) gapErrs++;
      checkOutput({tag, ".uniformGaps"}, gapErrs, 0);
    end else begin
      checkOutput({tag, ".frameLog"}, riseCyc.size(), NENT);
    end
  endtask

  initial begin
    vec_t vecs [4];
    bit   timedOut;
    compared   = 0;
    mismatched = 0;
    ctlCyc     = 0;
    ackDlyMode = 0;
    refAddr = '{15, 6, 0, 2, 3, 4, 5, 7, 8, 9};
    refData = '{'h000, 'h062, 'h117, 'h179, 'h079, 'h012, 'h000, 'h002, 'h000, 'h001};
    vecs[0] = '{ackDly: 0,  spurAt: -1, expWrites: NENT, expDoneRises: 1};
    vecs[1] = '{ackDly: 2,  spurAt: -1, expWrites: NENT, expDoneRises: 1};
    vecs[2] = '{ackDly: -1, spurAt: 3,  expWrites: NENT, expDoneRises: 1};
    vecs[3] = '{ackDly: -1, spurAt: 7,  expWrites: NENT, expDoneRises: 1};
`ifdef WM8731_VOLUME_EN
    vol_valid = 1'b0;
    vol_data  = '0;
`endif

    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset.busy", int'(busy), 0);
    checkOutput("reset.done", int'(done), 0);
    checkOutput("reset.req", int'(i2c_req), 0);
    checkOutput("reset.wdata", int'(i2c_wdata), 0);
    checkOutput("reset.addr", int'(i2c_addr), 'h1A);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("idle.noStart", int'(busy) + int'(i2c_req), 0);

    for (int i = 0; i < 4; i++) applyStimulus(vecs[i], i);

    // Reset while write 5 is waiting for its ack, then a clean restart.
    ackDlyMode = 3;
    doReset();
    pulseStart();
    timedOut = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (reqRises == 6 && i2c_req) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("midReset.reachWrite5", int'(timedOut), 0);
    reset = 1'b1;
    #1;
    checkOutput("midReset.req", int'(i2c_req), 0);
    checkOutput("midReset.busy", int'(busy), 0);
    checkOutput("midReset.done", int'(done), 0);
    checkOutput("midReset.wdata", int'(i2c_wdata), 0);
    doReset();
    ackDlyMode = -1;
    pulseStart();
    waitDone(timedOut);
    checkOutput("restart.timeout", int'(timedOut), 0);
    checkOutput("restart.writes", writes.size(), NENT);
    if (writes.size() > 0) checkOutput("restart.first", int'(writes[0]), 'h1E00);
    checkTable("restart");

`ifdef WM8731_VOLUME_EN
    repeat (5) @(negedge clk);
    checkOutput("vol.ready", int'(vol_ready), 1);
    vol_valid = 1'b1;
    vol_data  = 7'h79;
    @(negedge clk);
    vol_valid = 1'b0;
    vol_data  = '0;
    checkOutput("vol.busy", int'(busy), 1);
    checkOutput("vol.readyLow", int'(vol_ready), 0);
    timedOut = 1'b1;
    for (int c = 0; c < BUDGET; c++) begin
      @(negedge clk);
      if (!busy) begin
        timedOut = 1'b0;
        break;
      end
    end
    checkOutput("vol.timeout", int'(timedOut), 0);
    repeat (10) @(negedge clk);
    checkOutput("vol.writes", writes.size(), NENT + 1);
    if (writes.size() > NENT) checkOutput("vol.word", int'(writes[NENT]), 'h05F9);
    checkOutput("vol.doneHeld", int'(done), 1);
    checkOutput("vol.doneRises", doneRises, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
